// File: rtl/regf_arbiter.sv
// Two-port (I2C slave / local host) arbiter in front of the register file request interface.
// Optional build macro REGF_ARB_TIMEOUT_EN bounds the ISSUE wait and flags expiry on out_err.
module regf_arbiter #(
  parameter int DATA_WIDTH     = 8,
  parameter int ADDR_WIDTH     = 4,
  parameter int TIMEOUT_CYCLES = 15
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i2c_req,
  input  logic                  i2c_rw,
  input  logic [ADDR_WIDTH-1:0] i2c_addr,
  input  logic [DATA_WIDTH-1:0] i2c_write_data,
  output logic                  out_i2c_ack,
  output logic [DATA_WIDTH-1:0] out_i2c_read_data,
  input  logic                  host_req,
  input  logic                  host_rw,
  input  logic [ADDR_WIDTH-1:0] host_addr,
  input  logic [DATA_WIDTH-1:0] host_write_data,
  output logic                  out_host_ack,
  output logic [DATA_WIDTH-1:0] out_host_read_data,
  output logic                  out_regf_req,
  output logic                  out_regf_rw,
  output logic [ADDR_WIDTH-1:0] out_regf_addr,
  output logic [DATA_WIDTH-1:0] out_regf_write_data,
  input  logic [DATA_WIDTH-1:0] regf_read_data,
  input  logic                  regf_ack,
  output logic                  out_owner,
  output logic                  out_busy,
  output logic                  out_err
);

  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
    $error("regf_arbiter: TIMEOUT_CYCLES must be in 1..255");
  end

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_t;

  state_t                state, state_nxt;
  logic                  pick_host;
  logic                  done;
  logic [DATA_WIDTH-1:0] done_data;
  logic                  regf_req_nxt, regf_rw_nxt, owner_nxt, busy_nxt;
  logic [ADDR_WIDTH-1:0] regf_addr_nxt;
  logic [DATA_WIDTH-1:0] regf_wdata_nxt;
  logic                  i2c_ack_nxt, host_ack_nxt;
  logic [DATA_WIDTH-1:0] i2c_rdata_nxt, host_rdata_nxt;

`ifdef REGF_ARB_TIMEOUT_EN
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);
  logic [7:0] to_cnt, to_cnt_nxt;
  logic       err_nxt;
`endif

  always_comb begin
    state_nxt      = state;
    regf_req_nxt   = out_regf_req;
    regf_rw_nxt    = out_regf_rw;
    regf_addr_nxt  = out_regf_addr;
    regf_wdata_nxt = out_regf_write_data;
    owner_nxt      = out_owner;
    i2c_ack_nxt    = 1'b0;
    host_ack_nxt   = 1'b0;
    i2c_rdata_nxt  = out_i2c_read_data;
    host_rdata_nxt = out_host_read_data;
    done           = 1'b0;
    done_data      = '0;
`ifdef REGF_ARB_TIMEOUT_EN
    to_cnt_nxt     = to_cnt;
    err_nxt        = 1'b0;
`endif
    // On a tie the port that did not win last time goes next
    pick_host = (i2c_req && host_req) ? ~out_owner : host_req;

    case (state)
      IDLE: begin
        if (i2c_req || host_req) begin
          state_nxt      = ISSUE;
          owner_nxt      = pick_host;
          regf_req_nxt   = 1'b1;
          regf_rw_nxt    = pick_host ? host_rw         : i2c_rw;
          regf_addr_nxt  = pick_host ? host_addr       : i2c_addr;
          regf_wdata_nxt = pick_host ? host_write_data : i2c_write_data;
`ifdef REGF_ARB_TIMEOUT_EN
          to_cnt_nxt     = '0;
`endif
        end
      end
      ISSUE: begin
        if (regf_ack) begin
          done      = 1'b1;
          done_data = regf_read_data;
        end
`ifdef REGF_ARB_TIMEOUT_EN
        else if (to_cnt == TO_LAST) begin
          done    = 1'b1;
          err_nxt = 1'b1;
        end else begin
          to_cnt_nxt = to_cnt + 8'd1;
        end
`endif
      end
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase

    if (done) begin
      state_nxt    = RESP;
      regf_req_nxt = 1'b0;
      if (out_owner) begin
        host_ack_nxt   = 1'b1;
        host_rdata_nxt = done_data;
      end else begin
        i2c_ack_nxt    = 1'b1;
        i2c_rdata_nxt  = done_data;
      end
    end

    busy_nxt = (state_nxt != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state               <= IDLE;
      out_regf_req        <= 1'b0;
      out_regf_rw         <= 1'b0;
      out_regf_addr       <= '0;
      out_regf_write_data <= '0;
      out_owner           <= 1'b1;
      out_busy            <= 1'b0;
      out_i2c_ack         <= 1'b0;
      out_host_ack        <= 1'b0;
      out_i2c_read_data   <= '0;
      out_host_read_data  <= '0;
    end else begin
      state               <= state_nxt;
      out_regf_req        <= regf_req_nxt;
      out_regf_rw         <= regf_rw_nxt;
      out_regf_addr       <= regf_addr_nxt;
      out_regf_write_data <= regf_wdata_nxt;
      out_owner           <= owner_nxt;
      out_busy            <= busy_nxt;
      out_i2c_ack         <= i2c_ack_nxt;
      out_host_ack        <= host_ack_nxt;
      out_i2c_read_data   <= i2c_rdata_nxt;
      out_host_read_data  <= host_rdata_nxt;
    end
  end

`ifdef REGF_ARB_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      to_cnt  <= '0;
      out_err <= 1'b0;
    end else begin
      to_cnt  <= to_cnt_nxt;
      out_err <= err_nxt;
    end
  end
`else
  assign out_err = 1'b0;
`endif

endmodule

// File: tb/tb_regf_arbiter.sv
// Self-checking bench for regf_arbiter: reset, directed vector table, corner sequences,
// and a randomized two-requester run against a transaction-level reference model.
module tb_regf_arbiter;
  localparam int DW = 8;
  localparam int AW = 4;
  localparam int NEVER = 100000;

  logic          clk = 1'b0;
  logic          rst;
  logic          i2c_req, i2c_rw, host_req, host_rw;
  logic [AW-1:0] i2c_addr, host_addr;
  logic [DW-1:0] i2c_write_data, host_write_data;
  logic          out_i2c_ack, out_host_ack;
  logic [DW-1:0] out_i2c_read_data, out_host_read_data;
  logic          out_regf_req, out_regf_rw;
  logic [AW-1:0] out_regf_addr;
  logic [DW-1:0] out_regf_write_data;
  logic [DW-1:0] regf_read_data;
  logic          regf_ack;
  logic          out_owner, out_busy, out_err;

  always #5 clk = ~clk;

  regf_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .rst(rst),
    .i2c_req(i2c_req), .i2c_rw(i2c_rw), .i2c_addr(i2c_addr), .i2c_write_data(i2c_write_data),
    .out_i2c_ack(out_i2c_ack), .out_i2c_read_data(out_i2c_read_data),
    .host_req(host_req), .host_rw(host_rw), .host_addr(host_addr), .host_write_data(host_write_data),
    .out_host_ack(out_host_ack), .out_host_read_data(out_host_read_data),
    .out_regf_req(out_regf_req), .out_regf_rw(out_regf_rw), .out_regf_addr(out_regf_addr),
    .out_regf_write_data(out_regf_write_data), .regf_read_data(regf_read_data), .regf_ack(regf_ack),
    .out_owner(out_owner), .out_busy(out_busy), .out_err(out_err)
  );

  int total = 0;
  int bad   = 0;

  // Register-file responder model: acks after rf_delay_p[owner] wait cycles
  int            rf_delay_p [2];
  int            rf_cnt;
  bit            use_mem;
  logic [DW-1:0] rf_fixed;
  logic [DW-1:0] rf_shown;
  logic [DW-1:0] rf_mem [16];

  typedef struct {
    int            port;
    bit            rw;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    int            delay;
    logic [DW-1:0] rdata;
    bit            drop;
    int            lat;
  } vec_t;

  vec_t vecs [6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (out_regf_req === 1'b1) begin
      if (rf_cnt == rf_delay_p[out_owner]) begin
        regf_ack = 1'b1;
        if (!use_mem) regf_read_data = rf_fixed;
        else if (out_regf_rw) begin
          regf_read_data = 8'($urandom);
          rf_mem[out_regf_addr] = out_regf_write_data;
        end else regf_read_data = rf_mem[out_regf_addr];
        rf_shown = regf_read_data;
      end else begin
        regf_ack = 1'b0;
        regf_read_data = 8'($urandom);
      end
      rf_cnt++;
    end else begin
      regf_ack = 1'b0;
      regf_read_data = 8'($urandom);
      rf_cnt = 0;
    end
  endtask

  task automatic drive_port(input int p, input bit r, input bit rw, input logic [AW-1:0] a,
                            input logic [DW-1:0] d);
    if (p == 0) begin
      i2c_req = r; i2c_rw = rw; i2c_addr = a; i2c_write_data = d;
    end else begin
      host_req = r; host_rw = rw; host_addr = a; host_write_data = d;
    end
  endtask

  task automatic reset_dut();
    rst = 1'b1;
    drive_port(0, 0, 0, '0, '0);
    drive_port(1, 0, 0, '0, '0);
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    int            lat;
    bit            granted;
    logic [DW-1:0] other_rd;
    lat = 0;
    granted = 0;
    use_mem = 0;
    rf_fixed = v.rdata;
    rf_delay_p[0] = v.delay;
    rf_delay_p[1] = v.delay;
    other_rd = (v.port == 0) ? out_host_read_data : out_i2c_read_data;
    drive_port(v.port, 1, v.rw, v.addr, v.wdata);
    for (int k = 1; k <= 20 && lat == 0; k++) begin
      tick();
      if (!granted && out_regf_req) begin
        granted = 1;
        chk($sformatf("vec%0d owner", idx), out_owner, v.port);
        chk($sformatf("vec%0d regf_rw", idx), out_regf_rw, v.rw);
        chk($sformatf("vec%0d regf_addr", idx), out_regf_addr, v.addr);
        chk($sformatf("vec%0d regf_wdata", idx), out_regf_write_data, v.wdata);
        if (v.drop) drive_port(v.port, 0, v.rw, v.addr, v.wdata);
      end
      if (out_i2c_ack || out_host_ack) begin
        lat = k;
        chk($sformatf("vec%0d i2c_ack", idx), out_i2c_ack, v.port == 0);
        chk($sformatf("vec%0d host_ack", idx), out_host_ack, v.port == 1);
        chk($sformatf("vec%0d rdata", idx),
            (v.port == 0) ? out_i2c_read_data : out_host_read_data, v.rdata);
        chk($sformatf("vec%0d other_rdata", idx),
            (v.port == 0) ? out_host_read_data : out_i2c_read_data, other_rd);
        chk($sformatf("vec%0d err", idx), out_err, 0);
        drive_port(v.port, 0, v.rw, v.addr, v.wdata);
      end
    end
    chk($sformatf("vec%0d latency", idx), lat, v.lat);
    tick();
    chk($sformatf("vec%0d ack_width", idx), out_i2c_ack | out_host_ack, 0);
    chk($sformatf("vec%0d idle_busy", idx), out_busy, 0);
    tick();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int            n;
    int            ack_t [4];
    int            ack_p [4];
    int            lat;
    bit            pend [2];
    bit            prw [2];
    logic [AW-1:0] paddr [2];
    logic [DW-1:0] pdata [2];
    logic [DW-1:0] shadow [16];
    bit            active, cur, last_m, prev_rreq, g_obs, g_exp, w, r0, r1;
    int            due, free_t;

    vecs[0] = '{0, 1'b1, 4'h3, 8'hA5, 0, 8'h3C, 1'b0, 2};
    vecs[1] = '{1, 1'b0, 4'h7, 8'h00, 3, 8'h5C, 1'b0, 5};
    vecs[2] = '{0, 1'b0, 4'hF, 8'h11, 1, 8'h81, 1'b0, 3};
    vecs[3] = '{1, 1'b1, 4'h0, 8'h7E, 0, 8'h00, 1'b0, 2};
    vecs[4] = '{0, 1'b0, 4'h9, 8'h22, 2, 8'hFF, 1'b1, 4};
    vecs[5] = '{1, 1'b0, 4'hA, 8'h33, 0, 8'h12, 1'b1, 2};

    rst = 1'b1;
    regf_ack = 1'b0;
    regf_read_data = '0;
    use_mem = 0;
    rf_fixed = '0;
    rf_shown = '0;
    rf_cnt = 0;
    rf_delay_p[0] = 0;
    rf_delay_p[1] = 0;
    drive_port(0, 0, 0, '0, '0);
    drive_port(1, 0, 0, '0, '0);

    // Reset state
    tick();
    tick();
    chk("rst regf_req", out_regf_req, 0);
    chk("rst regf_rw", out_regf_rw, 0);
    chk("rst regf_addr", out_regf_addr, 0);
    chk("rst regf_wdata", out_regf_write_data, 0);
    chk("rst i2c_ack", out_i2c_ack, 0);
    chk("rst host_ack", out_host_ack, 0);
    chk("rst i2c_rdata", out_i2c_read_data, 0);
    chk("rst host_rdata", out_host_read_data, 0);
    chk("rst owner", out_owner, 1);
    chk("rst busy", out_busy, 0);
    chk("rst err", out_err, 0);
    rst = 1'b0;
    tick();
    chk("post-rst busy", out_busy, 0);

    for (int i = 0; i < 6; i++) run_vec(i, vecs[i]);

    // Contention from reset: strict alternation starting with I2C
    reset_dut();
    use_mem = 0;
    rf_fixed = 8'h33;
    rf_delay_p[0] = 0;
    rf_delay_p[1] = 0;
    for (int i = 0; i < 4; i++) begin ack_t[i] = -1; ack_p[i] = -1; end
    n = 0;
    drive_port(0, 1, 0, 4'h1, 8'h00);
    drive_port(1, 1, 0, 4'h2, 8'h00);
    for (int k = 1; k <= 12; k++) begin
      tick();
      chk("cont dual_ack", out_i2c_ack & out_host_ack, 0);
      if (out_i2c_ack || out_host_ack) begin
        if (n < 4) begin ack_t[n] = k; ack_p[n] = int'(out_host_ack); end
        n++;
      end
    end
    chk("cont ack_count", n, 4);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("cont grant%0d port", i), ack_p[i], i % 2);
      chk($sformatf("cont grant%0d tick", i), ack_t[i], 2 + 3 * i);
    end
    drive_port(0, 0, 0, '0, '0);
    drive_port(1, 0, 0, '0, '0);
    tick(); tick(); tick();

    // Reset while a transaction sits in ISSUE
    rf_delay_p[0] = NEVER;
    drive_port(0, 1, 0, 4'h5, 8'h00);
    tick(); tick(); tick();
    chk("midrst in_issue", out_regf_req, 1);
    rst = 1'b1;
    drive_port(0, 0, 0, '0, '0);
    tick();
    chk("midrst regf_req", out_regf_req, 0);
    chk("midrst busy", out_busy, 0);
    chk("midrst owner", out_owner, 1);
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("midrst no_ack", out_i2c_ack | out_host_ack, 0);
      chk("midrst idle", out_busy, 0);
    end

`ifdef REGF_ARB_TIMEOUT_EN
    // Timeout expiry, then ack arriving on the last allowed cycle
    use_mem = 0;
    rf_fixed = 8'h6D;
    rf_delay_p[1] = NEVER;
    drive_port(1, 1, 0, 4'h7, 8'h00);
    lat = 0;
    for (int k = 1; k <= 20 && lat == 0; k++) begin
      tick();
      if (out_host_ack || out_i2c_ack) begin
        lat = k;
        chk("tmo host_ack", out_host_ack, 1);
        chk("tmo err", out_err, 1);
        chk("tmo rdata", out_host_read_data, 0);
        chk("tmo i2c_ack", out_i2c_ack, 0);
        drive_port(1, 0, 0, '0, '0);
      end
    end
    chk("tmo latency", lat, 5);
    tick();
    chk("tmo err_width", out_err, 0);
    tick();
    rf_delay_p[1] = 3;
    drive_port(1, 1, 0, 4'h7, 8'h00);
    lat = 0;
    for (int k = 1; k <= 20 && lat == 0; k++) begin
      tick();
      if (out_host_ack || out_i2c_ack) begin
        lat = k;
        chk("ackwins err", out_err, 0);
        chk("ackwins rdata", out_host_read_data, 8'h6D);
        drive_port(1, 0, 0, '0, '0);
      end
    end
    chk("ackwins latency", lat, 5);
    tick(); tick();
`else
    // Without the timeout an unanswered request keeps the arbiter busy
    rf_delay_p[0] = NEVER;
    drive_port(0, 1, 0, 4'h4, 8'h00);
    for (int k = 1; k <= 40; k++) begin
      tick();
      chk("hang busy", out_busy, 1);
      chk("hang no_ack", out_i2c_ack | out_host_ack | out_err, 0);
    end
    reset_dut();
`endif

    // Randomized traffic against the transaction-level model
    reset_dut();
    use_mem = 1;
    for (int i = 0; i < 16; i++) begin
      shadow[i] = 8'($urandom);
      rf_mem[i] = shadow[i];
    end
    pend[0] = 0; pend[1] = 0;
    active = 0; cur = 0; last_m = 1; prev_rreq = 0;
    due = 0; free_t = 0;
    for (int t = 1; t <= 2000; t++) begin
      tick();
      r0 = i2c_req;
      r1 = host_req;
      g_obs = out_regf_req && !prev_rreq;
      prev_rreq = out_regf_req;
      g_exp = !active && (r0 || r1) && (t >= free_t);
      chk("rnd grant", g_obs, g_exp);
      if (g_exp && g_obs) begin
        w = (r0 && r1) ? !last_m : r1;
        chk("rnd owner", out_owner, w);
        chk("rnd regf_rw", out_regf_rw, prw[w]);
        chk("rnd regf_addr", out_regf_addr, paddr[w]);
        chk("rnd regf_wdata", out_regf_write_data, pdata[w]);
        active = 1;
        cur = w;
        last_m = w;
        due = t + 1 + rf_delay_p[w];
      end
      chk("rnd busy", out_busy, active);
      chk("rnd i2c_ack", out_i2c_ack, active && t == due && cur == 0);
      chk("rnd host_ack", out_host_ack, active && t == due && cur == 1);
      chk("rnd err", out_err, 0);
      if (active && t == due) begin
        chk("rnd rdata", cur ? out_host_read_data : out_i2c_read_data,
            prw[cur] ? rf_shown : shadow[paddr[cur]]);
        if (prw[cur]) shadow[paddr[cur]] = pdata[cur];
        active = 0;
        free_t = t + 2;
        pend[cur] = 0;
        drive_port(int'(cur), 0, 0, '0, '0);
      end
      for (int p = 0; p < 2; p++) begin
        if (!pend[p] && ($urandom_range(0, 3) == 0)) begin
          pend[p] = 1;
          prw[p] = 1'($urandom);
          paddr[p] = 4'($urandom);
          pdata[p] = 8'($urandom);
          rf_delay_p[p] = $urandom_range(0, 3);
          drive_port(p, 1, prw[p], paddr[p], pdata[p]);
        end
      end
    end
    drive_port(0, 0, 0, '0, '0);
    drive_port(1, 0, 0, '0, '0);
    tick(); tick(); tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/regf_arbiter.md
# regf_arbiter

Two-port arbiter and sequencer that shares the single request interface of the I2C register file between the I2C slave controller and a local host port. It latches one transaction at a time, drives the register file's req/rw/addr/data handshake, and returns the read data and a one-cycle acknowledge to the winning requester. It sits between the `i2c_slave_controller` and `reg_file` inside the top-level wrapper.

## Interface
**Parameters**
- `DATA_WIDTH`, default 8: register data width.
- `ADDR_WIDTH`, default 4: register address width.
- `TIMEOUT_CYCLES`, default 15: maximum number of cycles spent in `ISSUE`. Range 1–255. Used only with `REGF_ARB_TIMEOUT_EN`.

**Ports**
- `clk` in 1: single clock for all logic.
- `rst` in 1: synchronous, active-high reset.
- `i2c_req` in 1: I2C-side request, level.
- `i2c_rw` in 1: 1 = write, 0 = read.
- `i2c_addr` in ADDR_WIDTH: register address.
- `i2c_write_data` in DATA_WIDTH: write payload.
- `out_i2c_ack` out 1: one-cycle completion pulse.
- `out_i2c_read_data` out DATA_WIDTH: read result, valid while `out_i2c_ack`=1.
- `host_req`, `host_rw`, `host_addr`, `host_write_data`, `out_host_ack`, `out_host_read_data`: same meanings, for the host port.
- `out_regf_req` out 1: request to the register file.
- `out_regf_rw` out 1: register-file direction.
- `out_regf_addr` out ADDR_WIDTH: register-file address.
- `out_regf_write_data` out DATA_WIDTH: register-file write data.
- `regf_read_data` in DATA_WIDTH: register-file read data.
- `regf_ack` in 1: register-file completion, sampled while `out_regf_req`=1.
- `out_owner` out 1: current or last grant; 0 = I2C, 1 = host.
- `out_busy` out 1: high in every state except `IDLE`.
- `out_err` out 1: one-cycle timeout pulse, coincident with the ack.

## Operation
- All outputs are registered. After reset:
  - every req, ack, busy and err output is 0;
  - every data and address output is 0;
  - `out_owner`=1, so the I2C port wins the first tie.
- **Requester rule:**
  - Assert `req` with `rw`, `addr` and `write_data` stable.
  - Hold `req` until the ack is sampled high.
  - Drop `req` on the same edge that ends the ack cycle. A `req` still high in `IDLE` is treated as a new transaction.
- **FSM states:** `IDLE`, `ISSUE`, `RESP`.
- **IDLE**
  - No request: stay in `IDLE`.
  - Exactly one `req` high: grant that port.
  - Both high: grant the port not equal to `out_owner` (round-robin).
  - On grant: latch that port's `rw`, `addr` and `write_data` into the `out_regf_*` registers, set `out_owner`, set `out_regf_req`=1, go to `ISSUE`.
- **ISSUE**
  - Hold `out_regf_*` constant.
  - On `regf_ack`=1: capture `regf_read_data` into the owner's `out_*_read_data`, clear `out_regf_req`, pulse the owner's ack, go to `RESP`.
- **RESP**
  - Ack is high for exactly this cycle, then the FSM returns to `IDLE`.
  - The non-owner's ack is never asserted.
  - `out_*_read_data` holds its value until that port's next completion. On a write it is updated with whatever `regf_read_data` shows.
- Requests from the losing port wait without limit. Fairness: with both ports continuously requesting, grants alternate strictly.
- Reset mid-transaction: the FSM returns to `IDLE` on the next edge and all outputs take their reset values. An in-flight transaction is dropped and no ack is produced.
- `req` deasserted during `ISSUE` (protocol violation): the transaction still completes and the ack still pulses.

## Timing
- Request sampled high at edge N:
  - `out_regf_req`=1 from edge N+1.
  - If `regf_ack` is high in the first `ISSUE` cycle: ack high from edge N+2 to N+3, `IDLE` at N+3.
- Minimum request-to-ack latency is 2 cycles. Minimum spacing between grants is 3 cycles.
- Each cycle of `regf_ack` delay adds one cycle of latency.
- `out_busy` is high from N+1 through the `RESP` cycle.

## Configuration
- Macro `REGF_ARB_TIMEOUT_EN`.
- **Defined:**
  - An 8-bit counter clears on entry to `ISSUE` and increments each `ISSUE` cycle without `regf_ack`.
  - When the count reaches `TIMEOUT_CYCLES`: clear `out_regf_req`, load the owner's `out_*_read_data` with all zeros, pulse the owner's ack together with `out_err`, go to `RESP`.
  - If `regf_ack` arrives in the same cycle the count reaches `TIMEOUT_CYCLES`, the ack wins: normal completion, `out_err`=0.
- **Undefined:** no counter is built, `out_err` is tied to 0, and `ISSUE` waits without limit.

## Test plan
- **Reset:** assert `rst` for 2 cycles → all outputs 0, `out_owner`=1, `out_busy`=0.
- **I2C write:** I2C write addr 4'h3, data 8'hA5; `regf_ack` returned the first `ISSUE` cycle → `out_regf_addr`=3, `out_regf_write_data`=A5, `out_regf_rw`=1; `out_i2c_ack` high exactly 2 cycles after the req edge; `out_host_ack` stays 0.
- **Host read:** host read addr 4'h7 with `regf_read_data`=8'h5C and `regf_ack` delayed 3 cycles → `out_host_ack` 5 cycles after the request edge, `out_host_read_data`=5C.
- **Contention:** both ports request together from reset and keep requesting → grant order I2C, host, I2C, host; each ack is exactly one cycle wide.
- **Reset mid-transaction:** assert `rst` while in `ISSUE` → no ack, `out_regf_req`=0 the next cycle, FSM in `IDLE`.
- **Timeout (with `REGF_ARB_TIMEOUT_EN`, `TIMEOUT_CYCLES`=4):** hold `regf_ack` at 0 → ack and `out_err` pulse together, read data 8'h00; without the macro, `out_busy` stays high indefinitely.
